// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer.
// The select polarity matches the datapath's 2-to-1 selector: 1 picks A, 0 picks B.
package demux_pkg;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    // One-entry output slot occupancy; FULL is exactly "valid is high".
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/stream_slot.sv
// One-entry output holding register with its valid state, a wrapping
// transfer counter and load/drain control.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The consumer may raise or drop ready at any time. A slot can take a new
// word whenever it is empty or is draining on the same edge (can_load_o), so a
// consumer that holds ready high sees one word per cycle with no bubble.
module stream_slot
    import demux_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [WIDTH-1:0]     data_i,
    input  logic                 ready_i,
    output logic [WIDTH-1:0]     data_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 can_load_o,
    output slot_state_e          state_o
);

    slot_state_e          state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 drain;

    assign drain = (state_q == SLOT_FULL) && ready_i;

    // State, data and counter registers; reset drops any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // Next state: load fills, drain without load empties, otherwise hold.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            SLOT_EMPTY: if (load_i) state_d = SLOT_FULL;
            SLOT_FULL:  if (drain && !load_i) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
        if (load_i) data_d = data_i;
        // Counts words delivered downstream, not words accepted upstream.
        if (drain) count_d = count_q + CNT_WIDTH'(1);
    end

    // Outputs: registered data and counter, combinational load permission.
    always_comb begin
        data_o     = data_q;
        count_o    = count_q;
        state_o    = state_q;
        can_load_o = (state_q == SLOT_EMPTY) || ready_i;
    end

endmodule

// File: rtl/demux_1_to_2_stream.sv
// Registered 1-to-2 stream demultiplexer. Each input word goes to port A
// (in_sel = SEL_A) or port B (in_sel = SEL_B). Each port has its own slot, so a
// stalled port only blocks input while in_sel points at it.
module demux_1_to_2_stream
    import demux_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     a_data,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [WIDTH-1:0]     b_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [CNT_WIDTH-1:0] a_count,
    output logic [CNT_WIDTH-1:0] b_count
);

    logic        a_can_load, b_can_load;
    logic        a_load, b_load;
    slot_state_e a_state, b_state;

    // Input acceptance and load strobes; the non-selected slot is never loaded.
    always_comb begin
        in_ready = (in_sel == SEL_A) ? a_can_load : b_can_load;
        a_load   = in_valid && in_ready && (in_sel == SEL_A);
        b_load   = in_valid && in_ready && (in_sel == SEL_B);
        a_valid  = (a_state == SLOT_FULL);
        b_valid  = (b_state == SLOT_FULL);
    end

    stream_slot #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_slot_a (
        .clk        (clk),
        .rst        (rst),
        .load_i     (a_load),
        .data_i     (in_data),
        .ready_i    (a_ready),
        .data_o     (a_data),
        .count_o    (a_count),
        .can_load_o (a_can_load),
        .state_o    (a_state)
    );

    stream_slot #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_slot_b (
        .clk        (clk),
        .rst        (rst),
        .load_i     (b_load),
        .data_i     (in_data),
        .ready_i    (b_ready),
        .data_o     (b_data),
        .count_o    (b_count),
        .can_load_o (b_can_load),
        .state_o    (b_state)
    );

endmodule
